// File: rtl/md_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : md_seq_ctrl_if
// Purpose  : Bundles the EX-stage <-> multiply/divide sequencer signals.
//            master = EX stage (issues ops, reads HI/LO)
//            slave  = md_seq_ctrl (owns HI/LO, reports busy/stall/done)
// Signals  : md_start, md_op[2:0], md_a_data, md_b_data, md_read, md_flush
//            (EX -> sequencer); md_hi, md_lo, md_busy, md_stall, md_done
//            (sequencer -> EX)
// Revision : 1.0  initial release
// ============================================================================
interface md_seq_ctrl_if #(
   parameter int DATA_W = 32
);
   logic              md_start;
   logic [2:0]        md_op;
   logic [DATA_W-1:0] md_a_data;
   logic [DATA_W-1:0] md_b_data;
   logic              md_read;
   logic              md_flush;
   logic [DATA_W-1:0] md_hi;
   logic [DATA_W-1:0] md_lo;
   logic              md_busy;
   logic              md_stall;
   logic              md_done;

   modport master (
      output md_start, md_op, md_a_data, md_b_data, md_read, md_flush,
      input  md_hi, md_lo, md_busy, md_stall, md_done
   );

   modport slave (
      input  md_start, md_op, md_a_data, md_b_data, md_read, md_flush,
      output md_hi, md_lo, md_busy, md_stall, md_done
   );
endinterface
`default_nettype wire

// File: rtl/md_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : md_seq_ctrl
// Purpose  : Iterative multiply/divide sequencer for the EX stage. Owns the
//            HI/LO pair, runs MULT/MULTU (shift-add) and DIV/DIVU (restoring
//            divide) one bit per cycle, applies MTHI/MTLO, and requests a
//            pipeline stall for MD ops or HI/LO reads issued while busy.
// Ports    : clk, rst_n (async, active-low)
//            md : md_seq_ctrl_if.slave (op issue, HI/LO, busy/stall/done)
// Config   : MD_FAST_MUL_EN - multiplies use a single-cycle product latched
//            at accept and go straight to FIXUP; divides stay iterative.
// Revision : 1.0  initial release
// ============================================================================
module md_seq_ctrl #(
   parameter int                DATA_W  = 32,
   parameter int                CNT_W   = 6,
   parameter logic [DATA_W-1:0] DIV0_LO = {DATA_W{1'b1}}
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   md_seq_ctrl_if.slave     md
);
   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_RUN   = 2'd1;
   localparam logic [1:0] c_ST_FIXUP = 2'd2;

   localparam logic [2:0] c_OP_MULT  = 3'd1;
   localparam logic [2:0] c_OP_MULTU = 3'd2;
   localparam logic [2:0] c_OP_DIV   = 3'd3;
   localparam logic [2:0] c_OP_DIVU  = 3'd4;
   localparam logic [2:0] c_OP_MTHI  = 3'd5;
   localparam logic [2:0] c_OP_MTLO  = 3'd6;

   localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(DATA_W - 1);

   logic [1:0]          r_state, w_next_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_hi, r_lo;
   logic [DATA_W-1:0]   r_b;        // multiplicand (mul) or divisor (div), magnitude
   logic [DATA_W-1:0]   r_a_raw;    // dividend as issued, returned in HI on divide-by-zero
   logic [2*DATA_W-1:0] r_acc;      // mul: {partial, multiplier}; div: {remainder, quotient}
   logic                r_sign_a, r_sign_b, r_is_div, r_div0, r_done;
   logic                w_busy, w_stall;

   // ---------------- operation decode ----------------
   logic              w_mul_op, w_div_op, w_signed_op, w_md_op, w_accept;
   logic              w_sign_a, w_sign_b;
   logic [DATA_W-1:0] w_a_abs, w_b_abs;

   assign w_mul_op    = (md.md_op == c_OP_MULT) || (md.md_op == c_OP_MULTU);
   assign w_div_op    = (md.md_op == c_OP_DIV)  || (md.md_op == c_OP_DIVU);
   assign w_signed_op = (md.md_op == c_OP_MULT) || (md.md_op == c_OP_DIV);
   assign w_md_op     = w_mul_op || w_div_op;
   // Flush beats a same-cycle issue, including MTHI/MTLO.
   assign w_accept    = (r_state == c_ST_IDLE) && md.md_start && !md.md_flush;
   assign w_sign_a    = w_signed_op && md.md_a_data[DATA_W-1];
   assign w_sign_b    = w_signed_op && md.md_b_data[DATA_W-1];
   assign w_a_abs     = w_sign_a ? -md.md_a_data : md.md_a_data;
   assign w_b_abs     = w_sign_b ? -md.md_b_data : md.md_b_data;

`ifdef MD_FAST_MUL_EN
   logic [2*DATA_W-1:0] w_fast_prod;
   assign w_fast_prod = w_a_abs * w_b_abs;
`endif

   // ---------------- one engine iteration ----------------
   // Multiply: add multiplicand into the upper half when the current
   // multiplier bit is set, then shift the whole accumulator right, carry in.
   logic [DATA_W:0]     w_mul_sum;
   logic [2*DATA_W-1:0] w_mul_next;
   assign w_mul_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, r_b};
   assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[DATA_W-1:1]}
                                : {1'b0, r_acc[2*DATA_W-1:1]};

   // Restoring divide: shift next dividend bit into the remainder, subtract
   // divisor when it fits. The shifted remainder is always < 2*divisor, so
   // the difference fits in DATA_W bits.
   logic [DATA_W:0]     w_div_rem;
   logic [DATA_W-1:0]   w_div_sub;
   logic                w_div_ge;
   logic [2*DATA_W-1:0] w_div_next;
   assign w_div_rem  = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
   assign w_div_ge   = (w_div_rem >= {1'b0, r_b});
   assign w_div_sub  = w_div_rem[DATA_W-1:0] - r_b;
   assign w_div_next = w_div_ge ? {w_div_sub, r_acc[DATA_W-2:0], 1'b1}
                                : {w_div_rem[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0};

   // ---------------- sign fixup ----------------
   logic [2*DATA_W-1:0] w_prod;
   logic [DATA_W-1:0]   w_fix_hi, w_fix_lo;
   assign w_prod = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;

   always_comb begin
      w_fix_hi = w_prod[2*DATA_W-1:DATA_W];
      w_fix_lo = w_prod[DATA_W-1:0];
      if (r_is_div) begin
         if (r_div0) begin
            w_fix_hi = r_a_raw;
            w_fix_lo = DIV0_LO;
         end else begin
            w_fix_lo = (r_sign_a ^ r_sign_b) ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
            w_fix_hi = r_sign_a ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];
         end
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= c_ST_IDLE;
      else        r_state <= w_next_state;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (w_accept && w_md_op) begin
`ifdef MD_FAST_MUL_EN
               w_next_state = w_div_op ? c_ST_RUN : c_ST_FIXUP;
`else
               w_next_state = c_ST_RUN;
`endif
            end
         end
         c_ST_RUN: begin
            if (md.md_flush)              w_next_state = c_ST_IDLE;
            else if (r_cnt == c_LAST_CNT) w_next_state = c_ST_FIXUP;
         end
         c_ST_FIXUP: w_next_state = c_ST_IDLE;
         default:    w_next_state = c_ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      w_busy  = (r_state != c_ST_IDLE);
      w_stall = w_busy && (md.md_start || md.md_read);
   end

   // ---------------- datapath / HI-LO ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_b      <= '0;
         r_a_raw  <= '0;
         r_acc    <= '0;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_is_div <= 1'b0;
         r_div0   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            c_ST_IDLE: begin
               if (w_accept) begin
                  if (md.md_op == c_OP_MTHI) r_hi <= md.md_a_data;
                  if (md.md_op == c_OP_MTLO) r_lo <= md.md_a_data;
                  if (w_md_op) begin
                     r_sign_a <= w_sign_a;
                     r_sign_b <= w_sign_b;
                     r_is_div <= w_div_op;
                     r_div0   <= w_div_op && (md.md_b_data == '0);
                     r_a_raw  <= md.md_a_data;
                     r_cnt    <= '0;
                     r_b      <= w_div_op ? w_b_abs : w_a_abs;
                     r_acc    <= {{DATA_W{1'b0}}, (w_div_op ? w_a_abs : w_b_abs)};
`ifdef MD_FAST_MUL_EN
                     if (w_mul_op) r_acc <= w_fast_prod;
`endif
                  end
               end
            end
            c_ST_RUN: begin
               r_cnt <= r_cnt + 1'b1;
               r_acc <= r_is_div ? w_div_next : w_mul_next;
            end
            c_ST_FIXUP: begin
               if (!md.md_flush) begin
                  r_hi   <= w_fix_hi;
                  r_lo   <= w_fix_lo;
                  r_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign md.md_hi    = r_hi;
   assign md.md_lo    = r_lo;
   assign md.md_busy  = w_busy;
   assign md.md_stall = w_stall;
   assign md.md_done  = r_done;
endmodule
`default_nettype wire
